// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the receiver and transmitter.
//   rx_state_t       : receive framer state encoding
//   UART_OVERSAMPLE  : default oversample ticks per bit period
//   UART_DATA_BITS   : default data bits per frame
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Divides clk down to the oversample tick. The counter runs 0..CLK_DIV-1 and
// tick is high while it sits on CLK_DIV-1. While clr is high the counter is
// held at 0 and no tick is produced, so the first tick after clr falls
// arrives CLK_DIV cycles after the last cleared cycle.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : hold counter at zero
//   tick  : one-cycle oversample tick
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  logic [CW-1:0] cnt_r;

  // Clock-divider counter, wrapping at CLK_DIV-1 and held at zero by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign tick = (!clr) && (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_rx_framer.sv
// ---------------------------------------------------------------------------
// uart_rx_framer
// Oversampling UART receiver (start bit, DATA_BITS data bits LSB first, one
// stop bit). The rx pin is synchronised, a falling edge starts a frame, and
// every bit is sampled at mid-bit. Good frames are delivered through a
// valid/ready holding register; a bad stop bit or a full holding register
// is reported with a one-cycle pulse.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   rx         : asynchronous serial input, idles high
//   data_out   : byte held in the holding register
//   data_valid : holding register holds an unconsumed byte
//   data_ready : consumer takes data_out when data_valid && data_ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, good byte dropped (holding register full)
//   busy       : framer is not idle
// ---------------------------------------------------------------------------
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0]      OS_ZERO      = {OS_W{1'b0}};
  localparam logic [OS_W-1:0]      OS_ONE       = OS_W'(1'b1);
  localparam logic [OS_W-1:0]      OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]      OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]      BC_ZERO      = {BC_W{1'b0}};
  localparam logic [BC_W-1:0]      BC_ONE       = BC_W'(1'b1);
  localparam logic [BC_W-1:0]      BC_LAST      = BC_W'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] BYTE_ZERO    = {DATA_BITS{1'b0}};

  // Synchroniser and edge history: rx_sync_r is the clean rx level,
  // rx_hist_r is that level one cycle earlier.
  logic rx_meta_r;
  logic rx_sync_r;
  logic rx_hist_r;
  logic fall_s;

  rx_state_t            state_r;
  rx_state_t            state_next_s;
  logic [OS_W-1:0]      os_cnt_r;
  logic [OS_W-1:0]      os_cnt_next_s;
  logic [BC_W-1:0]      bit_cnt_r;
  logic [BC_W-1:0]      bit_cnt_next_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_next_s;
  logic                 good_frame_s;
  logic                 bad_frame_s;
  logic                 tick_s;
  logic                 tick_clr_s;

  logic [DATA_BITS-1:0] data_out_r;
  logic                 data_valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_hist_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_hist_r <= rx_sync_r;
    end
  end

  // Only a genuine 1->0 transition starts a frame; a line parked low
  // (break) never re-triggers.
  assign fall_s = rx_hist_r && !rx_sync_r;

  // The tick divider idles at zero, so its phase is aligned to the start edge.
  assign tick_clr_s = (state_r == IDLE);

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr_s),
    .tick  (tick_s)
  );

  // Framer next-state: oversample counting, mid-bit sampling and shifting.
  always_comb begin
    state_next_s   = state_r;
    os_cnt_next_s  = os_cnt_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    good_frame_s   = 1'b0;
    bad_frame_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_next_s  = START;
          os_cnt_next_s = OS_ZERO;
        end else begin
          state_next_s  = IDLE;
        end
      end

      START: begin
        if (tick_s) begin
          if (os_cnt_r == OS_HALF_LAST) begin
            // Middle of the start bit: a high line means a glitch.
            if (rx_sync_r) begin
              state_next_s   = IDLE;
            end else begin
              state_next_s   = DATA;
              os_cnt_next_s  = OS_ZERO;
              bit_cnt_next_s = BC_ZERO;
            end
          end else begin
            os_cnt_next_s = os_cnt_r + OS_ONE;
          end
        end else begin
          os_cnt_next_s = os_cnt_r;
        end
      end

      DATA: begin
        if (tick_s) begin
          if (os_cnt_r == OS_LAST) begin
            // Line order is LSB first, so shift in from the top.
            shift_next_s  = {rx_sync_r, shift_r[DATA_BITS-1:1]};
            os_cnt_next_s = OS_ZERO;
            if (bit_cnt_r == BC_LAST) begin
              state_next_s   = STOP;
              bit_cnt_next_s = BC_ZERO;
            end else begin
              bit_cnt_next_s = bit_cnt_r + BC_ONE;
            end
          end else begin
            os_cnt_next_s = os_cnt_r + OS_ONE;
          end
        end else begin
          os_cnt_next_s = os_cnt_r;
        end
      end

      STOP: begin
        if (tick_s) begin
          if (os_cnt_r == OS_LAST) begin
            state_next_s  = IDLE;
            os_cnt_next_s = OS_ZERO;
            if (rx_sync_r) begin
              good_frame_s = 1'b1;
            end else begin
              bad_frame_s  = 1'b1;
            end
          end else begin
            os_cnt_next_s = os_cnt_r + OS_ONE;
          end
        end else begin
          os_cnt_next_s = os_cnt_r;
        end
      end

      default: begin
        state_next_s   = IDLE;
        os_cnt_next_s  = OS_ZERO;
        bit_cnt_next_s = BC_ZERO;
      end
    endcase
  end

  // Framer state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      os_cnt_r  <= OS_ZERO;
      bit_cnt_r <= BC_ZERO;
      shift_r   <= BYTE_ZERO;
    end else begin
      state_r   <= state_next_s;
      os_cnt_r  <= os_cnt_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      shift_r   <= shift_next_s;
    end
  end

  // Holding register, error pulses and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r   <= BYTE_ZERO;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_err_r <= bad_frame_s;
      busy_r      <= (state_next_s != IDLE);
      if (good_frame_s) begin
        // A consumer draining in the same cycle frees the slot for the new byte.
        if (!data_valid_r || data_ready) begin
          data_out_r   <= shift_r;
          data_valid_r <= 1'b1;
          overrun_r    <= 1'b0;
        end else begin
          overrun_r    <= 1'b1;
        end
      end else if (data_valid_r && data_ready) begin
        data_valid_r <= 1'b0;
        overrun_r    <= 1'b0;
      end else begin
        overrun_r    <= 1'b0;
      end
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Oversampling UART 8N1 receiver. It is the far end of the serial line driven by the team's UART transmitter.
- Synchronises the asynchronous rx pin, detects the start edge, and samples each bit at mid-bit using an oversample tick.
- Checks the stop bit and delivers each byte through a valid/ready holding register, with framing-error and overrun reporting.
- Sits between the pad and the byte-stream consumer (FIFO or CPU register block).

Parameters:
- CLK_DIV, 4: clk cycles per oversample tick; must be >= 1.
- OVERSAMPLE, 16: ticks per bit period; must be even and >= 4.
- DATA_BITS, 8: data bits per frame, LSB first; range 5..8.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low. Deassertion is synchronous to clk outside this block.
- rx  in  1  serial input, asynchronous to clk; idles at 1.
- data_out  out  DATA_BITS  received byte held in the holding register.
- data_valid  out  1  holding register holds an unconsumed byte.
- data_ready  in  1  consumer accepts data_out when data_valid && data_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; shift reg 0; tick and bit counters 0.
  - Both synchroniser flops and the edge-detect history flop to 1.
  - Outputs: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - A reset mid-frame discards the partial byte; no pulse is emitted.
- Synchroniser:
  - Two flops produce rx_s. An edge on rx appears in rx_s 2 cycles later.
  - rx_q holds rx_s delayed by 1 cycle.
  - Falling edge = rx_q==1 && rx_s==0.
- Tick generator:
  - Counter runs 0..CLK_DIV-1; tick when it equals CLK_DIV-1.
  - Counter clears on the falling-edge detection cycle in IDLE, so the first tick is CLK_DIV cycles after detection.
  - Counter is held at 0 in IDLE.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge goes to START and clears the oversample count (os_cnt). A level low without an edge (line held in break) does not start a frame.
  - START: at os_cnt==OVERSAMPLE/2-1 on tick, sample rx_s.
    - rx_s=1: false start; return to IDLE.
    - rx_s=0: go to DATA; clear os_cnt and bit_cnt.
  - DATA: at os_cnt==OVERSAMPLE-1 on tick, sample rx_s, shift it into the MSB of the shift reg (LSB-first line order) and increment bit_cnt.
    - After sampling bit DATA_BITS-1, go to STOP.
  - STOP: at os_cnt==OVERSAMPLE-1 on tick, sample rx_s, then return to IDLE.
    - rx_s=1: good frame.
    - rx_s=0: frame_err=1 for the next cycle; byte discarded; holding register untouched.
- Sample instants, in ticks after detection: OVERSAMPLE/2 + k*OVERSAMPLE, k=0..DATA_BITS+1.
- Holding register (all updates registered):
  - Good frame with data_valid=0, or with data_valid=1 && data_ready=1 in the same cycle: load data_out and set data_valid=1. No overrun.
  - Good frame with data_valid=1 && data_ready=0: overrun=1 for one cycle; data_out and data_valid unchanged; new byte dropped.
  - data_valid && data_ready with no completing frame: data_valid=0 next cycle; data_out holds its value.
  - Stop sample to data_valid=1 latency: 1 cycle.
- frame_err and overrun are never both asserted, because a frame cannot be both good and bad.
- busy=1 from the cycle after detection until the cycle after the stop sample.
- Back-to-back frames are accepted: the next falling edge may occur immediately after the stop sample.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] rx_state_t {IDLE, START, DATA, STOP}.
  - Localparam defaults UART_OVERSAMPLE=16 and UART_DATA_BITS=8, shared with the transmitter.
- Sub-module uart_baud_tick: parameter CLK_DIV; ports clk, rst_n, clr, tick.
- The synchroniser, FSM and holding register stay in uart_rx_framer.

Test Plan:
- Send 0xA5 (8N1, CLK_DIV=4, OVERSAMPLE=16, 64 clk/bit) with data_ready=1 -> data_valid pulses once with data_out=0xA5, ~608 clk after the start edge reaches rx_s; frame_err=0, overrun=0.
- rx low for 20 clk (< half bit), then high -> FSM returns to IDLE from START; no data_valid, no frame_err; busy falls.
- Send 0x3C with stop bit forced 0 -> frame_err pulses for exactly 1 cycle; data_valid stays 0; line held low afterwards starts no new frame until rx returns to 1.
- data_ready=0, send 0x11 then 0x22 back-to-back -> data_out=0x11 with data_valid=1; overrun pulse at the second stop; data_out still 0x11. Then raise data_ready -> data_valid falls next cycle.
- data_valid=1 holding 0x55, send 0x66 with data_ready asserted exactly on the load cycle -> data_out=0x66, data_valid stays 1, no overrun.
- Assert rst_n=0 during bit 4 of a frame -> all outputs 0 immediately (async); after release a fresh 0x81 frame is received correctly.
